vga_tx_pacer: RTL and testbench
===============================

Name: vga_tx_pacer

Overview:
- Sits directly upstream of the 40x24 vga text display and owns its CPU-facing TX port: address, enable, w_en, din.
- Accepts character writes from the CPU/PIA display register into a small FIFO and returns a "display busy" flag (PIA DA bit 7).
- Replays each buffered character to the display as one clean write strobe followed by a release cycle, so the display's one-shot char_seen latch re-arms between characters.
- Optionally paces output to emulate the original terminal's character rate, and drives the display address high when idle so its background line-clear path keeps running.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CHAR_DELAY, 0, idle cycles inserted after each character's release cycle; 0 = full speed.
- DELAY_W, 24, width of the pacing counter; must hold CHAR_DELAY.

Ports:
- clk25 in 1: display pixel clock; every flop is on its rising edge.
- rst_n in 1: asynchronous, active-low reset.
- cpu_wr in 1: CPU write request to the display register; level, may be held for many cycles.
- cpu_din in 8: character written by the CPU; sampled on the cpu_wr rising edge.
- clr_screen in 1: synchronous clear request, same signal that feeds the display.
- busy out 1: 1 when the FIFO is full; this is the display-not-ready bit returned to the CPU.
- overflow out 1: sticky; set when a write is dropped because the FIFO is full.
- fill out log2(DEPTH)+1: current FIFO occupancy.
- vga_address out 1: drives the display address input.
- vga_enable out 1: drives the display enable input.
- vga_w_en out 1: drives the display w_en input.
- vga_din out 8: drives the display din input.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty, fill=0, busy=0, overflow=0.
  - FSM in IDLE, vga_address=1, vga_enable=0, vga_w_en=0, vga_din=8'h00.
  - Edge detector primed with cpu_wr_q=1, so a write held across reset release is not captured.
- Write side:
  - A push occurs on a cpu_wr 0->1 edge (cpu_wr & ~cpu_wr_q).
  - If fill < DEPTH, cpu_din is stored at the write pointer and fill increments.
  - If fill == DEPTH, the write is dropped and overflow is set; overflow clears only on reset or clr_screen.
- busy is combinational: busy = (fill == DEPTH).
- Pointers are log2(DEPTH) bits and wrap naturally; fill saturates at 0 and DEPTH.
- Pop and push in the same cycle: both take effect and fill is unchanged. This holds at fill == DEPTH, where the push is accepted because a slot frees that cycle.
- FSM:
  - IDLE:
    - Outputs vga_address=1, vga_enable=0, vga_w_en=0.
    - If fill != 0: pop the head into vga_din and go to STROBE.
  - STROBE (exactly 1 cycle):
    - Outputs vga_address=0, vga_enable=1, vga_w_en=1, vga_din held.
    - Go to RELEASE.
  - RELEASE (exactly 1 cycle):
    - Outputs vga_address=0, vga_enable=0, vga_w_en=0; this clears the display's char_seen latch.
    - If CHAR_DELAY == 0, go to IDLE.
    - Otherwise load the counter with CHAR_DELAY-1 and go to PACE.
  - PACE:
    - Outputs as in IDLE (vga_address=1).
    - Decrement the counter each cycle; go to IDLE on the cycle the counter reads 0.
- All vga_* outputs are registered.
- Minimum character period is 3 cycles when CHAR_DELAY=0, and 3+CHAR_DELAY otherwise.
- First strobe latency: push at cycle N puts the entry in the FIFO at N+1; the IDLE pop occurs at N+1; STROBE is visible on the outputs at N+2.
- clr_screen=1, synchronous, takes priority over everything:
  - FIFO flushed (pointers and fill to 0), overflow cleared, any push that cycle discarded.
  - FSM forced to IDLE with IDLE outputs and the counter zeroed.
  - A STROBE in progress is abandoned; the outputs return to IDLE values the next cycle.
- Characters pass through unmodified. Control-code interpretation (CR, ESC, etc.) belongs to the display.

Test Plan:
- Reset then one cpu_wr pulse with 8'hC1, CHAR_DELAY=0 -> exactly one cycle with address=0/enable=1/w_en=1/din=8'hC1, then one release cycle with all three at 0, then address=1; fill returns to 0.
- Burst of 5 writes (8'hC8,C5,CC,CC,CF) spaced 1 cycle apart, CHAR_DELAY=0 -> 5 strobes, in order, exactly 3 cycles apart; no strobe without a preceding release.
- 17 writes into DEPTH=16 while the output is stalled by CHAR_DELAY=1000 -> busy=1 at fill=16, 17th char dropped, overflow=1; all 16 stored chars later emitted in order.
- cpu_wr held high for 50 cycles with 8'hAA -> exactly one push and one strobe.
- CHAR_DELAY=10, two queued chars -> STROBE edges 13 cycles apart; vga_address=1 throughout PACE.
- clr_screen asserted during STROBE with 4 chars queued -> next cycle IDLE outputs; fill=0 and overflow=0; no further strobes until a new write.

Source files
------------

// File: rtl/vga_tx_pacer.sv
// vga_tx_pacer
//   Owns the CPU-facing TX port of the 40x24 text display. CPU character
//   writes are queued in a small FIFO. Each character is then replayed to the
//   display as one write strobe followed by one release cycle, which lets the
//   display's one-shot char_seen latch re-arm. Optional pacing adds idle
//   cycles between characters to emulate the original terminal's rate.
//
// Ports
//   clk25       : display pixel clock (all flops on rising edge)
//   rst_n       : asynchronous active-low reset
//   cpu_wr      : CPU write request (level); a push happens on its rising edge
//   cpu_din     : character sampled on the cpu_wr rising edge
//   clr_screen  : synchronous clear; flushes the FIFO and returns FSM to idle
//   busy        : FIFO full (display-not-ready bit back to the CPU)
//   overflow    : sticky, a write was dropped because the FIFO was full
//   fill        : current FIFO occupancy
//   vga_address : display address input, high while idle/pacing
//   vga_enable  : display enable input
//   vga_w_en    : display write enable input
//   vga_din     : display data input
module vga_tx_pacer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CHAR_DELAY = 0,
  parameter int unsigned DELAY_W    = 24
) (
  input  logic                       clk25,
  input  logic                       rst_n,
  input  logic                       cpu_wr,
  input  logic [7:0]                 cpu_din,
  input  logic                       clr_screen,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       vga_address,
  output logic                       vga_enable,
  output logic                       vga_w_en,
  output logic [7:0]                 vga_din
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [DELAY_W-1:0] RELOAD =
    (CHAR_DELAY == 0) ? '0 : DELAY_W'(CHAR_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    RELEASE,
    PACE
  } state_t;

  state_t               state_q, state_n;
  logic [DELAY_W-1:0]   cnt_q, cnt_n;
  logic                 wr_q;
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          fill_q;
  logic                 ovf_q;
  logic [7:0]           mem [DEPTH];

  logic                 push, pop, push_ok, drop;

  // Next-state and FIFO handshake decode.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pop     = 1'b0;
    push    = cpu_wr & ~wr_q;

    case (state_q)
      IDLE: begin
        if (fill_q != '0) begin
          pop     = 1'b1;
          state_n = STROBE;
        end
      end
      STROBE: state_n = RELEASE;
      RELEASE: begin
        if (CHAR_DELAY == 0) begin
          state_n = IDLE;
        end else begin
          cnt_n   = RELOAD;
          state_n = PACE;
        end
      end
      PACE: begin
        if (cnt_q == '0) state_n = IDLE;
        else             cnt_n   = cnt_q - DELAY_W'(1);
      end
      default: state_n = IDLE;
    endcase

    if (clr_screen) begin
      pop     = 1'b0;
      state_n = IDLE;
      cnt_n   = '0;
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push & ~clr_screen & ((fill_q != FULL) | pop);
    drop    = push & ~clr_screen & (fill_q == FULL) & ~pop;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b1;   // a write held across reset release is ignored
      wptr_q      <= '0;
      rptr_q      <= '0;
      fill_q      <= '0;
      ovf_q       <= 1'b0;
      vga_address <= 1'b1;
      vga_enable  <= 1'b0;
      vga_w_en    <= 1'b0;
      vga_din     <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      wr_q    <= cpu_wr;

      if (clr_screen) begin
        wptr_q <= '0;
        rptr_q <= '0;
        fill_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + AW'(1);
        if (pop)     rptr_q <= rptr_q + AW'(1);
        if (push_ok && !pop)      fill_q <= fill_q + (AW+1)'(1);
        else if (!push_ok && pop) fill_q <= fill_q - (AW+1)'(1);
        if (drop) ovf_q <= 1'b1;
      end

      // Outputs are registered from the next state so they line up with it.
      vga_address <= (state_n == IDLE) || (state_n == PACE);
      vga_enable  <= (state_n == STROBE);
      vga_w_en    <= (state_n == STROBE);
      if (pop) vga_din <= mem[rptr_q];
    end
  end

  // Storage has no reset; occupancy is tracked by fill_q alone.
  always_ff @(posedge clk25) begin
    if (push_ok) mem[wptr_q] <= cpu_din;
  end

  assign busy     = (fill_q == FULL);
  assign overflow = ovf_q;
  assign fill     = fill_q;

endmodule

// File: tb/tb_vga_tx_pacer.sv
module tb_vga_tx_pacer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance 0: CHAR_DELAY=0, instance 1: CHAR_DELAY=1000, instance 2: CHAR_DELAY=10
  logic [2:0]      wr;
  logic [2:0]      clr;
  logic [7:0]      din [3];
  logic [2:0]      busy, ovf, addr, en, wen;
  logic [2:0][7:0] vdin;
  logic [2:0][4:0] fill;

  vga_tx_pacer #(.DEPTH(16), .CHAR_DELAY(0), .DELAY_W(24)) u_d0 (
    .clk25(clk), .rst_n(rst_n), .cpu_wr(wr[0]), .cpu_din(din[0]), .clr_screen(clr[0]),
    .busy(busy[0]), .overflow(ovf[0]), .fill(fill[0]), .vga_address(addr[0]),
    .vga_enable(en[0]), .vga_w_en(wen[0]), .vga_din(vdin[0]));

  vga_tx_pacer #(.DEPTH(16), .CHAR_DELAY(1000), .DELAY_W(24)) u_d1 (
    .clk25(clk), .rst_n(rst_n), .cpu_wr(wr[1]), .cpu_din(din[1]), .clr_screen(clr[1]),
    .busy(busy[1]), .overflow(ovf[1]), .fill(fill[1]), .vga_address(addr[1]),
    .vga_enable(en[1]), .vga_w_en(wen[1]), .vga_din(vdin[1]));

  vga_tx_pacer #(.DEPTH(16), .CHAR_DELAY(10), .DELAY_W(24)) u_d2 (
    .clk25(clk), .rst_n(rst_n), .cpu_wr(wr[2]), .cpu_din(din[2]), .clr_screen(clr[2]),
    .busy(busy[2]), .overflow(ovf[2]), .fill(fill[2]), .vga_address(addr[2]),
    .vga_enable(en[2]), .vga_w_en(wen[2]), .vga_din(vdin[2]));

  typedef struct {
    int         k;
    int         c;
    logic [7:0] d;
  } strobe_t;

  strobe_t    sq[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         cons_err = 0;
  int         proto_err = 0;
  logic [2:0] prev_wen = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log plus display-protocol watch on every instance.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (wen[k]) begin
          strobe_t s;
          s.k = k; s.c = cyc; s.d = vdin[k];
          sq.push_back(s);
          if (prev_wen[k]) cons_err++;
        end
        if ((en[k] !== wen[k]) || (wen[k] && addr[k])) proto_err++;
      end
      prev_wen = wen;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(int k, logic [7:0] d);
    wr[k] = 1'b1;
    din[k] = d;
    tick();
    wr[k] = 1'b0;
    tick();
  endtask

  function automatic int n_str(int k);
    int n = 0;
    foreach (sq[i]) if (sq[i].k == k) n++;
    return n;
  endfunction

  function automatic strobe_t nth(int k, int j);
    strobe_t r;
    int n = 0;
    r.k = -1; r.c = 0; r.d = '0;
    foreach (sq[i]) begin
      if (sq[i].k == k) begin
        if (n == j) r = sq[i];
        n++;
      end
    end
    return r;
  endfunction

  task automatic wait_str(int k, int n, int budget, string tag);
    int b = 0;
    while (n_str(k) < n && b < budget) begin
      tick();
      b++;
    end
    chk(tag, n_str(k), n);
  endtask

  initial begin
    strobe_t    s, s1;
    int         t0, base, cnt, b, s0c;
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] burst [5];

    wr = '0; clr = '0;
    for (int k = 0; k < 3; k++) din[k] = '0;

    // Write held high across reset release must not be captured.
    wr[0] = 1'b1; din[0] = 8'h11;
    repeat (3) tick();
    chk("rst_fill", fill[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_addr", addr[0], 1);
    chk("rst_en", en[0], 0);
    chk("rst_wen", wen[0], 0);
    chk("rst_din", vdin[0], 8'h00);
    chk("rst_addr_all", addr, 3'b111);
    rst_n = 1'b1;
    repeat (5) tick();
    wr[0] = 1'b0;
    repeat (5) tick();
    chk("held_wr_fill", fill[0], 0);
    chk("held_wr_strobes", n_str(0), 0);

    // Single character: latency, strobe, release, return to idle.
    t0 = cyc;
    pulse(0, 8'hC1);
    wait_str(0, 1, 20, "single_count");
    s = nth(0, 0);
    chk("single_latency", s.c - t0, 2);
    chk("single_din", s.d, 8'hC1);
    b = 0;
    while (cyc < s.c + 1 && b < 10) begin tick(); b++; end
    chk("release_addr", addr[0], 0);
    chk("release_en", en[0], 0);
    chk("release_wen", wen[0], 0);
    tick();
    chk("after_addr", addr[0], 1);
    chk("after_fill", fill[0], 0);
    repeat (5) tick();
    chk("single_only_one", n_str(0), 1);

    // Burst of five, strobes exactly three cycles apart.
    burst[0] = 8'hC8; burst[1] = 8'hC5; burst[2] = 8'hCC; burst[3] = 8'hCC; burst[4] = 8'hCF;
    base = n_str(0);
    for (int j = 0; j < 5; j++) pulse(0, burst[j]);
    wait_str(0, base + 5, 100, "burst_count");
    for (int j = 0; j < 5; j++) begin
      s = nth(0, base + j);
      chk("burst_din", s.d, burst[j]);
      if (j > 0) begin
        s1 = nth(0, base + j - 1);
        chk("burst_gap", s.c - s1.c, 3);
      end
    end

    // Level held for 50 cycles gives exactly one character.
    base = n_str(0);
    wr[0] = 1'b1; din[0] = 8'hAA;
    repeat (50) tick();
    wr[0] = 1'b0;
    repeat (10) tick();
    chk("hold_count", n_str(0), base + 1);
    s = nth(0, base);
    chk("hold_din", s.d, 8'hAA);

    // Random writes against an in-order queue model.
    base = n_str(0);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      pulse(0, d);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_str(0, base + 20, 200, "rand_count");
    for (int j = 0; j < 20; j++) begin
      s = nth(0, base + j);
      chk("rand_din", s.d, q[j]);
      if (j > 0) begin
        s1 = nth(0, base + j - 1);
        chk("rand_gap_ge3", (s.c - s1.c) >= 3, 1);
      end
    end
    chk("rand_ovf", ovf[0], 0);

    // Clear on the same cycle as a push discards the push.
    base = n_str(0);
    wr[0] = 1'b1; din[0] = 8'h77; clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    tick();
    wr[0] = 1'b0;
    repeat (6) tick();
    chk("clr_push_strobes", n_str(0), base);
    chk("clr_push_fill", fill[0], 0);

    // CHAR_DELAY=10: 13-cycle period, address high throughout pacing.
    base = n_str(2);
    pulse(2, 8'h41);
    pulse(2, 8'h42);
    cnt = 0; b = 0;
    while (!wen[2] && b < 40) begin
      if (addr[2]) cnt++;
      tick();
      b++;
    end
    chk("pace_addr_high", cnt, b);
    chk("pace_idle_len", b, 11);
    wait_str(2, base + 2, 60, "pace_count");
    s1 = nth(2, base); s = nth(2, base + 1);
    chk("pace_period", s.c - s1.c, 13);
    chk("pace_din", s.d, 8'h42);

    // Clear during a strobe with four characters queued.
    repeat (20) tick();
    base = n_str(2);
    for (int j = 0; j < 6; j++) pulse(2, 8'(8'h30 + j));
    b = 0;
    while (!wen[2] && b < 40) begin tick(); b++; end
    chk("clr_at_strobe", wen[2], 1);
    chk("clr_fill_before", fill[2], 4);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    chk("clr_addr", addr[2], 1);
    chk("clr_en", en[2], 0);
    chk("clr_wen", wen[2], 0);
    chk("clr_fill", fill[2], 0);
    chk("clr_ovf", ovf[2], 0);
    repeat (40) tick();
    chk("clr_no_more", n_str(2), base + 2);
    pulse(2, 8'h55);
    wait_str(2, base + 3, 20, "clr_new_count");
    s = nth(2, base + 2);
    chk("clr_new_din", s.d, 8'h55);

    // CHAR_DELAY=1000: fill to full, overflow, push+pop at full, ordered drain.
    pulse(1, 8'hD0);
    wait_str(1, 1, 10, "stall_prime");
    s0c = nth(1, 0).c;
    for (int j = 0; j < 16; j++) pulse(1, 8'(8'h60 + j));
    chk("full_fill", fill[1], 16);
    chk("full_busy", busy[1], 1);
    chk("full_ovf", ovf[1], 0);
    pulse(1, 8'h7F);
    chk("drop_ovf", ovf[1], 1);
    chk("drop_fill", fill[1], 16);
    b = 0;
    while (cyc < s0c + 1002 && b < 2000) begin tick(); b++; end
    wr[1] = 1'b1; din[1] = 8'h5A;
    tick();
    wr[1] = 1'b0;
    tick();
    chk("pushpop_fill", fill[1], 16);
    chk("pushpop_ovf", ovf[1], 1);
    chk("pushpop_strobes", n_str(1), 2);
    wait_str(1, 18, 20000, "drain_count");
    for (int j = 0; j < 18; j++) begin
      s = nth(1, j);
      chk("drain_din", s.d, (j == 0) ? 8'hD0 : (j == 17) ? 8'h5A : 8'(8'h60 + j - 1));
      if (j > 0) begin
        s1 = nth(1, j - 1);
        chk("drain_gap", s.c - s1.c, 1003);
      end
    end
    chk("drain_busy", busy[1], 0);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("ovf_cleared", ovf[1], 0);

    chk("no_back_to_back_strobe", cons_err, 0);
    chk("protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
